// File: rtl/conv_window.sv
// conv_window: builds K x K pixel neighbourhoods from a raster-order pixel
// stream using K-1 shift-register line buffers, and emits one flattened
// window for every position where a complete (unpadded) window exists.
module conv_window #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int K      = 3,
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic [DATA_W-1:0]     din,
   input  logic                  din_vld,
   output logic [K*K*DATA_W-1:0] win,
   output logic                  win_vld,
   output logic                  frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic              accept;
   logic              last_col;
   logic              last_row;
   logic              emit;

   // line_buf[i][IMG_W-1] holds the pixel of the same column, i+1 rows up
   logic [DATA_W-1:0] line_buf [K-1][IMG_W];
   logic [DATA_W-1:0] win_sr   [K][K];
   logic [DATA_W-1:0] win_nxt  [K][K];

   // clear takes priority over a coincident pixel, which is dropped
   assign accept   = din_vld && !clear;
   assign last_col = (col == CW'(IMG_W - 1));
   assign last_row = (row == RW'(IMG_H - 1));
   assign emit     = (row >= RW'(K - 1)) && (col >= CW'(K - 1));

   // Next window contents: existing columns move left, the newest column
   // (K-1 buffered pixels plus the incoming pixel) enters on the right
   always_comb begin
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++) begin
            win_nxt[r][c] = win_sr[r][c+1];
         end
      end
      for (int r = 0; r < K - 1; r++) begin
         win_nxt[r][K-1] = line_buf[K-2-r][IMG_W-1];
      end
      win_nxt[K-1][K-1] = din;
   end

   // Line buffers are chained: each buffer's oldest pixel feeds the next one;
   // their contents survive reset and clear since stale rows are never emitted
   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         for (int i = 0; i < K - 1; i++) begin
            for (int j = IMG_W - 1; j > 0; j--) begin
               line_buf[i][j] <= line_buf[i][j-1];
            end
            if (i == 0) begin
               line_buf[i][0] <= din;
            end else begin
               line_buf[i][0] <= line_buf[i-1][IMG_W-1];
            end
         end
      end
   end

   // Internal window shift register advances on every accepted pixel,
   // including positions that do not produce an output
   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         win_sr <= win_nxt;
      end
   end

   // Raster counters, output window capture and the single-cycle pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         col        <= '0;
         row        <= '0;
         win        <= '0;
         win_vld    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         win_vld    <= 1'b0;
         frame_done <= 1'b0;
         if (clear) begin
            col <= '0;
            row <= '0;
         end else if (din_vld) begin
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
            if (emit) begin
               win_vld <= 1'b1;
               for (int r = 0; r < K; r++) begin
                  for (int c = 0; c < K; c++) begin
                     win[DATA_W*(r*K+c) +: DATA_W] <= win_nxt[r][c];
                  end
               end
            end
            frame_done <= last_col && last_row;
         end
      end
   end

endmodule
